grid_mem_arbiter: RTL and testbench

- Shares one single-port synchronous grid RAM between the VGA pattern reader and the game-logic engine.
- The RAM holds one entity code per 40x30 grid cell.
- VGA reads have priority. Game writes are buffered in a small FIFO so game logic rarely stalls.
- A starvation counter guarantees the game port forward progress during long active-video runs.

---
 rtl/grid_mem_arbiter_if.sv | 43 ++++
 rtl/grid_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_grid_mem_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/grid_mem_arbiter_if.sv
// Signal bundle between the grid RAM arbiter, its two clients and the RAM.
// The arbiter takes the slave view; clients and RAM together take the master view.
interface grid_mem_arbiter_if #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              vga_rd_req;
  logic [ADDR_W-1:0] vga_rd_addr;
  logic [DATA_W-1:0] vga_rd_data;
  logic              vga_rd_valid;
  logic              g_wr_valid;
  logic              g_wr_ready;
  logic [ADDR_W-1:0] g_wr_addr;
  logic [DATA_W-1:0] g_wr_data;
  logic              g_rd_valid;
  logic              g_rd_ready;
  logic [ADDR_W-1:0] g_rd_addr;
  logic [DATA_W-1:0] g_rd_data;
  logic              g_rd_data_valid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [LVL_W-1:0]  fifo_level;

  modport slave (
    input  vga_rd_req, vga_rd_addr, g_wr_valid, g_wr_addr, g_wr_data,
           g_rd_valid, g_rd_addr, mem_rdata,
    output vga_rd_data, vga_rd_valid, g_wr_ready, g_rd_ready, g_rd_data,
           g_rd_data_valid, mem_en, mem_we, mem_addr, mem_wdata, fifo_level
  );

  modport master (
    output vga_rd_req, vga_rd_addr, g_wr_valid, g_wr_addr, g_wr_data,
           g_rd_valid, g_rd_addr, mem_rdata,
    input  vga_rd_data, vga_rd_valid, g_wr_ready, g_rd_ready, g_rd_data,
           g_rd_data_valid, mem_en, mem_we, mem_addr, mem_wdata, fifo_level
  );
endinterface

// File: rtl/grid_mem_arbiter.sv
// Shares a single-port grid RAM between VGA reads (priority) and game-logic
// writes/reads; game writes are queued, and a starvation counter forces game slots.
module grid_mem_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  grid_mem_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_VGA  = 2'd1,
    GNT_GAME = 2'd2
  } grant_e;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              vga_vld_q, g_vld_q;
  logic [DATA_W-1:0] vga_hold_q, g_hold_q;

  grant_e grant_s;
  logic   fifo_nonempty_s, game_pending_s, wr_ready_s, push_s, pop_s, g_rd_go_s;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    fifo_nonempty_s = (level_q != {LVL_W{1'b0}});
    game_pending_s  = fifo_nonempty_s || bus.g_rd_valid;
    grant_s         = GNT_IDLE;
    if (reset) begin
      grant_s = GNT_IDLE;
    end else if (game_pending_s && (starve_q == CNT_W'(STARVE_MAX))) begin
      grant_s = GNT_GAME;
    end else if (bus.vga_rd_req) begin
      grant_s = GNT_VGA;
    end else if (game_pending_s) begin
      grant_s = GNT_GAME;
    end else begin
      grant_s = GNT_IDLE;
    end
  end

  // RAM port drive; queued writes drain before any game read is serviced.
  always_comb begin
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = {ADDR_W{1'b0}};
    bus.mem_wdata  = {DATA_W{1'b0}};
    bus.g_rd_ready = 1'b0;
    pop_s          = 1'b0;
    g_rd_go_s      = 1'b0;
    case (grant_s)
      GNT_VGA: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.vga_rd_addr;
      end
      GNT_GAME: begin
        bus.mem_en = 1'b1;
        if (fifo_nonempty_s) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = fifo_addr_q[rd_ptr_q];
          bus.mem_wdata = fifo_data_q[rd_ptr_q];
          pop_s         = 1'b1;
        end else begin
          bus.mem_addr   = bus.g_rd_addr;
          bus.g_rd_ready = 1'b1;
          g_rd_go_s      = 1'b1;
        end
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

  // FIFO occupancy and starvation counter next state.
  always_comb begin
    wr_ready_s = !reset && (level_q < LVL_W'(FIFO_DEPTH));
    push_s     = bus.g_wr_valid && wr_ready_s;
    if (push_s && !pop_s) begin
      level_d = level_q + LVL_W'(1);
    end else if (pop_s && !push_s) begin
      level_d = level_q - LVL_W'(1);
    end else begin
      level_d = level_q;
    end
    if ((grant_s == GNT_GAME) || !game_pending_s) begin
      starve_d = {CNT_W{1'b0}};
    end else if (starve_q != CNT_W'(STARVE_MAX)) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // Control state: pointers, level, counter and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      level_q    <= {LVL_W{1'b0}};
      starve_q   <= {CNT_W{1'b0}};
      vga_vld_q  <= 1'b0;
      g_vld_q    <= 1'b0;
      vga_hold_q <= {DATA_W{1'b0}};
      g_hold_q   <= {DATA_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q   <= level_d;
      starve_q  <= starve_d;
      vga_vld_q <= (grant_s == GNT_VGA);
      g_vld_q   <= g_rd_go_s;
      if (vga_vld_q) vga_hold_q <= bus.mem_rdata;
      if (g_vld_q)   g_hold_q   <= bus.mem_rdata;
    end
  end

  // Write FIFO storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= bus.g_wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.g_wr_data;
    end
  end

  // Client-facing outputs; returned data comes straight from the RAM output register.
  always_comb begin
    bus.g_wr_ready = wr_ready_s;
    if (reset) begin
      bus.fifo_level      = {LVL_W{1'b0}};
      bus.vga_rd_valid    = 1'b0;
      bus.vga_rd_data     = {DATA_W{1'b0}};
      bus.g_rd_data_valid = 1'b0;
      bus.g_rd_data       = {DATA_W{1'b0}};
    end else begin
      bus.fifo_level      = level_q;
      bus.vga_rd_valid    = vga_vld_q;
      bus.vga_rd_data     = vga_vld_q ? bus.mem_rdata : vga_hold_q;
      bus.g_rd_data_valid = g_vld_q;
      bus.g_rd_data       = g_vld_q ? bus.mem_rdata : g_hold_q;
    end
  end
endmodule

// File: tb/tb_grid_mem_arbiter.sv
// Randomized and directed stimulus for grid_mem_arbiter, checked each cycle
// against a queue-based reference model with a shadow copy of the grid.
module tb_grid_mem_arbiter;
  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 15;
  localparam int CELLS      = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grid_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  grid_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Power-up grid contents: cells 0,1,2 hold 5,3,1.
  function automatic logic [DATA_W-1:0] init_val(input int a);
    return DATA_W'(5 - 2 * a);
  endfunction

  // Single-port synchronous RAM with 1-cycle read latency.
  logic [DATA_W-1:0] ram [CELLS];
  bit                ram_wr [CELLS];
  always @(posedge clk) begin
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]    <= bus.mem_wdata;
        ram_wr[bus.mem_addr] <= 1'b1;
      end else begin
        bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_val(int'(bus.mem_addr));
      end
    end
  end

  // Reference model state
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t               fq[$];
  logic [DATA_W-1:0] shadow [CELLS];
  int                starve;
  bit                m_vv, m_gv, m_rd_acc;
  logic [DATA_W-1:0] m_vresp, m_vhold, m_gresp, m_ghold;
  int                n_chk = 0;
  int                n_fail = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge, advance model.
  task automatic step(input bit rst, input bit vreq, input int vaddr,
                      input bit wv, input int waddr, input int wdata,
                      input bit rv, input int raddr);
    int lvl, gnt;
    bit pend, wrdy, push, pop, rgo;
    @(posedge clk);
    #1;
    reset           = rst;
    bus.vga_rd_req  = vreq;
    bus.vga_rd_addr = ADDR_W'(vaddr);
    bus.g_wr_valid  = wv;
    bus.g_wr_addr   = ADDR_W'(waddr);
    bus.g_wr_data   = DATA_W'(wdata);
    bus.g_rd_valid  = rv;
    bus.g_rd_addr   = ADDR_W'(raddr);
    @(negedge clk);
    if (rst) begin
      check_eq("rst_mem_en", int'(bus.mem_en), 0);
      check_eq("rst_g_wr_ready", int'(bus.g_wr_ready), 0);
      check_eq("rst_g_rd_ready", int'(bus.g_rd_ready), 0);
      check_eq("rst_fifo_level", int'(bus.fifo_level), 0);
      check_eq("rst_vga_rd_valid", int'(bus.vga_rd_valid), 0);
      check_eq("rst_g_rd_data_valid", int'(bus.g_rd_data_valid), 0);
      fq.delete();
      starve = 0; m_vv = 0; m_gv = 0; m_rd_acc = 0;
      m_vhold = '0; m_ghold = '0;
    end else begin
      lvl  = fq.size();
      pend = (lvl > 0) || rv;
      if (pend && starve == STARVE_MAX) gnt = 2;
      else if (vreq)                    gnt = 1;
      else if (pend)                    gnt = 2;
      else                              gnt = 0;
      wrdy = lvl < FIFO_DEPTH;
      push = wv && wrdy;
      pop  = (gnt == 2) && (lvl > 0);
      rgo  = (gnt == 2) && (lvl == 0);

      check_eq("mem_en", int'(bus.mem_en), int'(gnt != 0));
      if (gnt != 0) check_eq("mem_we", int'(bus.mem_we), int'(pop));
      if (gnt == 1) check_eq("mem_addr_vga", int'(bus.mem_addr), vaddr);
      if (pop) begin
        check_eq("mem_addr_wr", int'(bus.mem_addr), int'(fq[0].a));
        check_eq("mem_wdata", int'(bus.mem_wdata), int'(fq[0].d));
      end
      if (rgo) check_eq("mem_addr_rd", int'(bus.mem_addr), raddr);
      check_eq("g_rd_ready", int'(bus.g_rd_ready), int'(rgo));
      check_eq("g_wr_ready", int'(bus.g_wr_ready), int'(wrdy));
      check_eq("fifo_level", int'(bus.fifo_level), lvl);
      check_eq("vga_rd_valid", int'(bus.vga_rd_valid), int'(m_vv));
      check_eq("vga_rd_data", int'(bus.vga_rd_data), int'(m_vv ? m_vresp : m_vhold));
      check_eq("g_rd_data_valid", int'(bus.g_rd_data_valid), int'(m_gv));
      check_eq("g_rd_data", int'(bus.g_rd_data), int'(m_gv ? m_gresp : m_ghold));

      if (m_vv) m_vhold = m_vresp;
      if (m_gv) m_ghold = m_gresp;
      m_vv = (gnt == 1);
      if (gnt == 1) m_vresp = shadow[vaddr];
      m_gv = rgo;
      if (rgo) m_gresp = shadow[raddr];
      if (pop) begin
        shadow[fq[0].a] = fq[0].d;
        void'(fq.pop_front());
      end
      if (push) fq.push_back('{a: ADDR_W'(waddr), d: DATA_W'(wdata)});
      if (gnt == 2 || !pend)        starve = 0;
      else if (starve < STARVE_MAX) starve = starve + 1;
      m_rd_acc = rgo;
    end
  endtask

  initial begin
    bit rd_out;
    int rd_addr, n;
    for (int i = 0; i < CELLS; i++) shadow[i] = init_val(i);
    reset = 1'b1;
    bus.vga_rd_req = 1'b0; bus.vga_rd_addr = '0;
    bus.g_wr_valid = 1'b0; bus.g_wr_addr = '0; bus.g_wr_data = '0;
    bus.g_rd_valid = 1'b0; bus.g_rd_addr = '0;

    // Reset with every request active, then first idle cycle
    repeat (2) step(1'b1, 1'b1, 3, 1'b1, 7, 7, 1'b1, 7);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);

    // VGA-only reads of cells 0,1,2
    for (int a = 0; a < 3; a++) step(1'b0, 1'b1, a, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    check_eq("vga_hold_last", int'(bus.vga_rd_data), 1);

    // FIFO fill under continuous VGA traffic; forced slots drain it slowly
    for (int k = 0; k < 40; k++)
      step(1'b0, 1'b1, k % 3, k < 5, 200 + k, k + 1, 1'b0, 0);
    check_eq("fill_level_after_forced", int'(bus.fifo_level), 2);
    repeat (4) step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    check_eq("fill_drained", int'(bus.fifo_level), 0);

    // Read-after-write on cell 100
    step(1'b0, 1'b0, 0, 1'b1, 100, 6, 1'b0, 0);
    n = 0;
    do begin
      step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 100);
      n++;
    end while (!m_rd_acc && n < 20);
    check_eq("raw_accepted", int'(m_rd_acc), 1);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    check_eq("raw_data", int'(bus.g_rd_data), 6);

    // VGA wins a tie, then the game read goes once VGA drops
    step(1'b0, 1'b1, 5, 1'b0, 0, 0, 1'b1, 9);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 9);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);

    // Reset while writes are queued and a read is requested
    step(1'b0, 1'b1, 1, 1'b1, 300, 3, 1'b0, 0);
    step(1'b0, 1'b1, 2, 1'b1, 301, 4, 1'b0, 0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b1, 301);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0);

    // Random traffic, alternating light and heavy VGA load
    rd_out = 1'b0;
    rd_addr = 0;
    for (int i = 0; i < 3000; i++) begin
      int pct;
      pct = ((i / 400) % 2 == 1) ? 97 : 45;
      if (rd_out && m_rd_acc) rd_out = 1'b0;
      if (!rd_out && $urandom_range(0, 3) == 0) begin
        rd_out = 1'b1;
        rd_addr = ($urandom_range(0, 19) == 0) ? 1199 : int'($urandom_range(0, 15));
      end
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 99) < pct, int'($urandom_range(0, 1199)),
           $urandom_range(0, 2) == 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
           rd_out, rd_addr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
